// File: rtl/seg_scan_if.sv
// ---------------------------------------------------------------------------
// seg_scan_if
// Bundle between the counter/stopwatch datapath and the 7-segment scanner.
//   master : datapath side, drives display value, masks and display options
//   slave  : scanner side, drives the board an/seg/dp pins and frame_tick
// Signals:
//   en          scan enable
//   bcd_num     nibble i = digit i, digit 0 rightmost / least significant
//   dp_in       decimal point request per digit
//   digit_en    per-digit enable, 0 blanks that digit
//   lz_suppress blank leading zeros
//   hex_mode    show A-F for nibbles > 9 (otherwise blank)
//   brightness  0 = dark .. 15 = full
//   an          digit anodes, an[i] drives digit i
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point
//   frame_tick  one-cycle pulse at each frame start
// ---------------------------------------------------------------------------
interface seg_scan_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                      en;
   logic [4*NUM_DIGITS-1:0]   bcd_num;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic [NUM_DIGITS-1:0]     digit_en;
   logic                      lz_suppress;
   logic                      hex_mode;
   logic [3:0]                brightness;
   logic [NUM_DIGITS-1:0]     an;
   logic [6:0]                seg;
   logic                      dp;
   logic                      frame_tick;

   modport master (
      output en, bcd_num, dp_in, digit_en, lz_suppress, hex_mode, brightness,
      input  an, seg, dp, frame_tick
   );

   modport slave (
      input  en, bcd_num, dp_in, digit_en, lz_suppress, hex_mode, brightness,
      output an, seg, dp, frame_tick
   );
endinterface

// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// A slot counter divides clk into SCAN_DIV-cycle digit slots; the first
// BLANK_CYCLES of each slot keep all anodes off to suppress ghosting. A
// free-running 4-bit PWM counter gates the lit window for brightness. The
// display value and decimal points are captured once per frame so a frame
// never mixes two values.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  seg_scan_if.slave (options and value in, an/seg/dp/frame_tick out)
// ---------------------------------------------------------------------------
module seg_scan_mux #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SCAN_DIV       = 25000,
   parameter int unsigned BLANK_CYCLES   = 1000,
   parameter int unsigned AN_ACTIVE_LOW  = 1,
   parameter int unsigned SEG_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   seg_scan_if.slave  bus
);

   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned BW = 4 * NUM_DIGITS;

   localparam logic                  AN_LOW  = (AN_ACTIVE_LOW != 0);
   localparam logic                  SEG_LOW = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_LOW}};
   localparam logic [6:0]            SEG_OFF = {7{SEG_LOW}};

   // Active-high glyph {g..a}; nibbles above 9 only render in hex mode.
   function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
      logic [6:0] g;
      g = 7'h00;
      case (nib)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = hex ? 7'h77 : 7'h00;
         4'hB: g = hex ? 7'h7C : 7'h00;
         4'hC: g = hex ? 7'h39 : 7'h00;
         4'hD: g = hex ? 7'h5E : 7'h00;
         4'hE: g = hex ? 7'h79 : 7'h00;
         4'hF: g = hex ? 7'h71 : 7'h00;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   // state
   logic [SW-1:0]         slot_cnt_q,   slot_cnt_d;
   logic [IW-1:0]         digit_idx_q,  digit_idx_d;
   logic [3:0]            pwm_cnt_q,    pwm_cnt_d;
   logic [BW-1:0]         snap_num_q,   snap_num_d;
   logic [NUM_DIGITS-1:0] snap_dp_q,    snap_dp_d;
   logic [NUM_DIGITS-1:0] an_q,         an_d;
   logic [6:0]            seg_q,        seg_d;
   logic                  dp_q,         dp_d;
   logic                  frame_tick_q, frame_tick_d;

   // combinational helpers
   logic                  frame_start_c;
   logic [BW-1:0]         view_num_c;
   logic [NUM_DIGITS-1:0] view_dp_c;
   logic [3:0]            cur_nib_c;
   logic                  cur_dp_c;
   logic                  cur_en_c;
   logic [NUM_DIGITS-1:0] an_sel_c;
   logic                  upper_zero_c;
   logic                  lz_blank_c;
   logic [6:0]            cur_glyph_c;
   logic                  pwm_on_c;
   logic                  base_on_c;
   logic                  digit_on_c;

   // Frame starts at slot 0 of digit 0; the capture cycle already shows the
   // value being captured so the whole frame renders one snapshot.
   always_comb begin
      frame_start_c = bus.en && (slot_cnt_q == '0) && (digit_idx_q == '0);
      view_num_c    = frame_start_c ? bus.bcd_num : snap_num_q;
      view_dp_c     = frame_start_c ? bus.dp_in   : snap_dp_q;
   end

   // Slot divider, digit index, PWM counter and frame snapshot.
   always_comb begin
      slot_cnt_d  = slot_cnt_q;
      digit_idx_d = digit_idx_q;
      pwm_cnt_d   = pwm_cnt_q;
      snap_num_d  = snap_num_q;
      snap_dp_d   = snap_dp_q;
      if (bus.en) begin
         pwm_cnt_d = pwm_cnt_q + 4'd1;
         if (slot_cnt_q == SW'(SCAN_DIV - 1)) begin
            slot_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == IW'(NUM_DIGITS - 1)) ? '0
                                                               : digit_idx_q + IW'(1);
         end else begin
            slot_cnt_d = slot_cnt_q + SW'(1);
         end
         if (frame_start_c) begin
            snap_num_d = bus.bcd_num;
            snap_dp_d  = bus.dp_in;
         end
      end
   end

   // Select the current digit; scanning top-down accumulates "all nibbles
   // from here to the most significant are zero" for leading-zero blanking.
   always_comb begin
      cur_nib_c    = 4'h0;
      cur_dp_c     = 1'b0;
      cur_en_c     = 1'b0;
      an_sel_c     = '0;
      upper_zero_c = 1'b1;
      lz_blank_c   = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         upper_zero_c = upper_zero_c && (view_num_c[4*i +: 4] == 4'h0);
         if (digit_idx_q == IW'(i)) begin
            cur_nib_c   = view_num_c[4*i +: 4];
            cur_dp_c    = view_dp_c[i];
            cur_en_c    = bus.digit_en[i];
            an_sel_c[i] = 1'b1;
            lz_blank_c  = bus.lz_suppress && (i != 0) && upper_zero_c;
         end
      end
   end

   // Lit decision; a glyph-blanked digit still lights when its dp is set.
   always_comb begin
      cur_glyph_c = glyph(cur_nib_c, bus.hex_mode);
      pwm_on_c    = (bus.brightness == 4'hF) || (pwm_cnt_q < bus.brightness);
      base_on_c   = (slot_cnt_q >= SW'(BLANK_CYCLES)) && cur_en_c && pwm_on_c
                    && !lz_blank_c;
      digit_on_c  = base_on_c && ((cur_glyph_c != 7'h00) || cur_dp_c);
   end

   // Output pins, polarity applied before the register.
   always_comb begin
      an_d         = AN_OFF;
      seg_d        = SEG_OFF;
      dp_d         = SEG_LOW;
      frame_tick_d = 1'b0;
      if (bus.en) begin
         frame_tick_d = frame_start_c;
         if (digit_on_c) begin
            an_d  = an_sel_c ^ AN_OFF;
            seg_d = cur_glyph_c ^ SEG_OFF;
            dp_d  = cur_dp_c ^ SEG_LOW;
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt_q   <= '0;
         digit_idx_q  <= '0;
         pwm_cnt_q    <= 4'h0;
         snap_num_q   <= '0;
         snap_dp_q    <= '0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= SEG_LOW;
         frame_tick_q <= 1'b0;
      end else begin
         slot_cnt_q   <= slot_cnt_d;
         digit_idx_q  <= digit_idx_d;
         pwm_cnt_q    <= pwm_cnt_d;
         snap_num_q   <= snap_num_d;
         snap_dp_q    <= snap_dp_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_mux
// Bench for seg_scan_mux with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 and
// active-low anodes and segments. The reference tracks a single position
// count of enabled cycles since reset and derives slot, digit and PWM phase
// from it arithmetically.
// ---------------------------------------------------------------------------
module tb_seg_scan_mux;

   localparam int N  = 4;
   localparam int SD = 8;
   localparam int BL = 2;
   localparam logic [12:0] OFF_VEC = {4'hF, 7'h7F, 1'b1, 1'b0};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg_scan_if #(.NUM_DIGITS(N)) bus ();

   seg_scan_mux #(
      .NUM_DIGITS     (N),
      .SCAN_DIV       (SD),
      .BLANK_CYCLES   (BL),
      .AN_ACTIVE_LOW  (1),
      .SEG_ACTIVE_LOW (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // reference state
   int          pos;
   logic [15:0] m_num;
   logic [3:0]  m_dp;
   logic [12:0] exp_vec;
   logic [6:0]  g_tbl [16];

   function automatic logic [12:0] dut_vec();
      return {bus.an, bus.seg, bus.dp, bus.frame_tick};
   endfunction

   // Predict the outputs produced by the coming edge, then take the edge.
   task automatic step();
      int         slot, d, pwm;
      logic [3:0] n;
      logic [6:0] g;
      logic [3:0] a;
      logic       base, on, ft;
      exp_vec = OFF_VEC;
      if (rst) begin
         pos   = 0;
         m_num = '0;
         m_dp  = '0;
      end else if (bus.en) begin
         slot = pos % SD;
         d    = (pos / SD) % N;
         pwm  = pos % 16;
         ft   = 1'b0;
         if (pos % (SD * N) == 0) begin
            m_num = bus.bcd_num;
            m_dp  = bus.dp_in;
            ft    = 1'b1;
         end
         n    = m_num[4*d +: 4];
         g    = (n <= 4'd9 || bus.hex_mode) ? g_tbl[n] : 7'h00;
         base = (slot >= BL) && bus.digit_en[d]
                && (bus.brightness == 4'd15 || pwm < int'(bus.brightness))
                && !(bus.lz_suppress && d > 0 && ((m_num >> (4*d)) == 16'h0));
         on   = base && (g != 7'h00 || m_dp[d]);
         if (on) begin
            a       = 4'b0001 << d;
            exp_vec = {~a, ~g, ~m_dp[d], ft};
         end else begin
            exp_vec[0] = ft;
         end
         pos++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      bus.en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (dut_vec() !== OFF_VEC) begin
            errors++;
            $display("FAIL reset_state c=%0d got %h want %h", c, dut_vec(), OFF_VEC);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int ticks, last_tick, lit;
      apply_reset();
      bus.bcd_num = 16'h1234; bus.digit_en = 4'hF; bus.brightness = 4'd15;
      bus.dp_in = 4'h0; bus.lz_suppress = 1'b0; bus.hex_mode = 1'b0; bus.en = 1'b1;
      ticks = 0; last_tick = -1; lit = 0;
      for (int c = 0; c < 64; c++) begin
         step();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL basic c=%0d got %h want %h", c, dut_vec(), exp_vec);
         end
         if (bus.an !== 4'hF) lit++;
         if (bus.frame_tick === 1'b1) begin
            if (last_tick >= 0) begin
               checks++;
               if (c - last_tick !== 32) begin
                  errors++;
                  $display("FAIL tick_period got %0d want 32", c - last_tick);
               end
            end
            last_tick = c;
            ticks++;
         end
      end
      checks++;
      if (ticks !== 2) begin
         errors++;
         $display("FAIL tick_count got %0d want 2", ticks);
      end
      checks++;
      if (lit !== 48) begin
         errors++;
         $display("FAIL lit_cycles got %0d want 48", lit);
      end
   endtask

   task automatic test_tearing();
      apply_reset();
      bus.bcd_num = 16'h1234;
      for (int c = 0; c < 64; c++) begin
         if (c == 12) bus.bcd_num = 16'h5678;
         step();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL tearing c=%0d got %h want %h", c, dut_vec(), exp_vec);
         end
         if (bus.an === 4'hB) begin
            checks++;
            if (bus.seg !== ((c < 32) ? 7'h24 : 7'h02)) begin
               errors++;
               $display("FAIL tearing_digit2 c=%0d got %h want %h", c, bus.seg,
                        (c < 32) ? 7'h24 : 7'h02);
            end
         end
      end
   endtask

   task automatic test_lz();
      apply_reset();
      bus.lz_suppress = 1'b1;
      bus.bcd_num     = 16'h0007;
      for (int c = 0; c < 96; c++) begin
         if (c == 32) bus.bcd_num = 16'h0000;
         step();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL lz c=%0d got %h want %h", c, dut_vec(), exp_vec);
         end
         checks++;
         if (bus.an !== 4'hF && bus.an !== 4'hE) begin
            errors++;
            $display("FAIL lz_anode c=%0d got %h want E or F", c, bus.an);
         end
         if (bus.an === 4'hE && (c < 32 || c >= 64)) begin
            checks++;
            if (bus.seg !== ((c < 32) ? 7'h78 : 7'h40)) begin
               errors++;
               $display("FAIL lz_digit0 c=%0d got %h want %h", c, bus.seg,
                        (c < 32) ? 7'h78 : 7'h40);
            end
         end
      end
      bus.lz_suppress = 1'b0;
   endtask

   task automatic test_brightness();
      apply_reset();
      bus.bcd_num    = 16'h1234;
      bus.brightness = 4'd4;
      for (int c = 0; c < 96; c++) begin
         if (c == 64) bus.brightness = 4'd0;
         step();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL brightness c=%0d got %h want %h", c, dut_vec(), exp_vec);
         end
         if (bus.an !== 4'hF) begin
            checks++;
            if (c >= 64 || (c % 16) >= 4) begin
               errors++;
               $display("FAIL pwm_gate c=%0d got %h want F", c, bus.an);
            end
         end
      end
      bus.brightness = 4'd15;
   endtask

   task automatic test_hex();
      int lit;
      apply_reset();
      bus.bcd_num  = 16'h000B;
      bus.digit_en = 4'h1;
      bus.hex_mode = 1'b1;
      bus.dp_in    = 4'h0;
      lit = 0;
      for (int c = 0; c < 160; c++) begin
         if (c == 32) begin bus.hex_mode = 1'b0; bus.dp_in = 4'h1; end
         if (c == 96) bus.dp_in = 4'h0;
         step();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL hex c=%0d got %h want %h", c, dut_vec(), exp_vec);
         end
         if (c < 32 && bus.an === 4'hE) begin
            checks++;
            if (bus.seg !== 7'h03) begin
               errors++;
               $display("FAIL hex_b got %h want 03", bus.seg);
            end
         end
         if (c >= 64 && c < 96 && bus.an === 4'hE) begin
            lit++;
            checks++;
            if ({bus.seg, bus.dp} !== {7'h7F, 1'b0}) begin
               errors++;
               $display("FAIL blank_dp got %h want %h", {bus.seg, bus.dp}, {7'h7F, 1'b0});
            end
         end
         if (c >= 128) begin
            checks++;
            if (bus.an !== 4'hF) begin
               errors++;
               $display("FAIL blank_nodp c=%0d got %h want F", c, bus.an);
            end
         end
      end
      checks++;
      if (lit !== 6) begin
         errors++;
         $display("FAIL blank_dp_lit got %0d want 6", lit);
      end
      bus.digit_en = 4'hF;
      bus.hex_mode = 1'b0;
   endtask

   task automatic test_rst_mid();
      apply_reset();
      bus.bcd_num = 16'h1234;
      for (int c = 0; c < 19; c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (dut_vec() !== OFF_VEC) begin
         errors++;
         $display("FAIL rst_mid got %h want %h", dut_vec(), OFF_VEC);
      end
      for (int c = 0; c < 13; c++) begin
         if (c == 5) bus.en = 1'b0;
         if (c == 9) bus.en = 1'b1;
         step();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL rst_resume c=%0d got %h want %h", c, dut_vec(), exp_vec);
         end
         if (c == 3) begin
            checks++;
            if (bus.an !== 4'hE) begin
               errors++;
               $display("FAIL first_slot got %h want E", bus.an);
            end
         end
         if (c >= 5 && c < 9) begin
            checks++;
            if (dut_vec() !== OFF_VEC) begin
               errors++;
               $display("FAIL en_low c=%0d got %h want %h", c, dut_vec(), OFF_VEC);
            end
         end
      end
      // slot 0 resumes at its held count, then slot 1 follows
      for (int c = 0; c < 12; c++) begin
         step();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL en_resume c=%0d got %h want %h", c, dut_vec(), exp_vec);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) bus.en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0)  bus.bcd_num = 16'($urandom);
         if ($urandom_range(0, 2) == 0) bus.bcd_num[15:8] = 8'h00;
         if ($urandom_range(0, 19) == 0) bus.dp_in = 4'($urandom);
         if ($urandom_range(0, 29) == 0) bus.digit_en = 4'($urandom);
         if ($urandom_range(0, 29) == 0) bus.lz_suppress = 1'($urandom);
         if ($urandom_range(0, 29) == 0) bus.hex_mode = 1'($urandom);
         if ($urandom_range(0, 29) == 0) bus.brightness = 4'($urandom);
         step();
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++;
            $display("FAIL random c=%0d got %h want %h", c, dut_vec(), exp_vec);
         end
         checks++;
         if ($countones(~bus.an) > 1) begin
            errors++;
            $display("FAIL one_anode c=%0d got %h want at most one low", c, bus.an);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      g_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      pos = 0; m_num = '0; m_dp = '0; exp_vec = OFF_VEC;
      rst             = 1'b1;
      bus.en          = 1'b0;
      bus.bcd_num     = 16'h0000;
      bus.dp_in       = 4'h0;
      bus.digit_en    = 4'hF;
      bus.lz_suppress = 1'b0;
      bus.hex_mode    = 1'b0;
      bus.brightness  = 4'd15;

      test_reset();
      test_basic();
      test_tearing();
      test_lz();
      test_brightness();
      test_hex();
      test_rst_mid();
      test_random();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised successor of the 4-digit BCD 7-segment scanner: drives NUM_DIGITS common-anode digits from a system clock through an internal scan divider; no separate slow clock.
- Adds anti-ghost blanking, 16-level PWM brightness, and leading-zero suppression.
- Adds decimal points, hex glyphs, a per-digit enable mask, and a per-frame snapshot of the display value (no tearing).
- Sits between the stopwatch/counter datapath and the board's an/seg/dp pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 25000, clk cycles per digit slot (>= 2).
- BLANK_CYCLES, 1000, cycles at slot start with all anodes off (< SCAN_DIV).
- AN_ACTIVE_LOW, 1, 1 = anode outputs active-low.
- SEG_ACTIVE_LOW, 1, 1 = segment and dp outputs active-low.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  scan enable.
- bcd_num  in  4*NUM_DIGITS  nibble i = digit i; digit 0 is the rightmost and least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit.
- lz_suppress  in  1  1 = blank leading zeros.
- hex_mode  in  1  1 = show nibble values A-F; 0 = nibbles >9 are blanked.
- brightness  in  4  0 = dark, 15 = full.
- an  out  NUM_DIGITS  digit anodes; an[i] drives digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset: taken at the clk edge with rst=1. State after reset:
  - slot_cnt=0, digit_idx=0, pwm_cnt=0, snapshot=0.
  - an, seg and dp all inactive at their configured polarity; frame_tick=0.
  - Reset mid-frame aborts the frame; the first slot after reset is digit 0.
- slot_cnt:
  - Counts 0..SCAN_DIV-1 while en=1.
  - At SCAN_DIV-1 it wraps to 0 and digit_idx advances: i -> i+1, and NUM_DIGITS-1 -> 0.
- pwm_cnt: 4-bit free-running counter that increments every en=1 cycle and wraps 15 -> 0.
- Snapshot:
  - When en=1, slot_cnt=0 and digit_idx=0, bcd_num and dp_in are copied into snapshot registers.
  - In that same cycle frame_tick is asserted on the next edge (one-cycle registered pulse).
  - lz_suppress, hex_mode, digit_en and brightness are used live, not snapshotted.
- en=0:
  - All counters hold.
  - an, seg and dp go inactive on the next edge.
  - frame_tick=0.
  - Scanning resumes from the held position.
- Lit condition for the current digit d = digit_idx. All of the following must hold; otherwise every anode is inactive:
  - slot_cnt >= BLANK_CYCLES.
  - digit_en[d] = 1.
  - brightness = 15, or pwm_cnt < brightness.
  - d is not leading-zero blanked.
  - The glyph is not blank.
- Leading-zero blanking:
  - Applies when lz_suppress=1, d > 0, and snapshot nibbles d..NUM_DIGITS-1 are all 0.
  - Digit 0 is never zero-suppressed.
- Glyphs, shown as active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - With hex_mode=1: A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Nibbles >9 with hex_mode=0 are blank (00).
- dp output:
  - Equals snapshot dp[d] while the digit is lit, including a digit blanked only for its glyph.
  - In that case the anode is still asserted if dp[d]=1.
  - Otherwise dp is inactive.
- Output latency and polarity:
  - an, seg and dp are registered: the value at edge t+1 reflects the counters, snapshot and inputs at cycle t.
  - Active-low parameters invert at the output register.
  - At most one anode is active at any time.
- Simultaneous events: rst has priority over en. A snapshot and a digit advance in the same cycle are legal; the snapshot uses the pre-edge bcd_num.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, both polarities active-low):
- Reset then en=1, bcd_num=16'h1234, digit_en=F, brightness=15:
  - an cycles E,D,B,7 with 8 cycles per slot.
  - Each slot has 2 cycles with an=F, then 6 lit cycles.
  - seg = ~06 on digit 3, ~5B on digit 2, ~4F on digit 1, ~66 on digit 0.
  - frame_tick pulses every 32 cycles.
- Tearing: change bcd_num to 16'h5678 mid-frame -> the remainder of the frame still shows 1234; the next frame shows 5678.
- lz_suppress=1, bcd_num=16'h0007 -> digits 3..1 never lit; digit 0 shows ~07. With bcd_num=16'h0000, only digit 0 is lit, showing ~3F.
- brightness=4 -> in the lit window, an is asserted only when pwm_cnt is 0..3. With brightness=0 -> an stays F throughout.
- hex_mode toggle with nibble B:
  - hex_mode=1 -> seg=~7C.
  - hex_mode=0 -> glyph blank. With dp_in=1 the anode is still asserted with seg=~00 and dp=0 (active-low); with dp_in=0 the anode is off.
- Assert rst in slot 2 -> next edge: an=F, seg=7F, dp=1. en=0 mid-slot -> outputs inactive; resuming continues the same slot count.
